// File: rtl/id_imm_stage_pkg.sv
// Shared definitions for the decode-stage immediate sequencer: opcode constants,
// immediate format codes, buffer states and the payload carried to ID/EX.
package id_imm_stage_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_SE11 = 3'd1,
    FMT_SE8  = 3'd2,
    FMT_ZE8  = 3'd3,
    FMT_SE4  = 3'd4,
    FMT_SE5  = 3'd5,
    FMT_SH3  = 3'd6
  } fmt_e;

  localparam logic [4:0] OP_SE11_B = 5'b00010;
  localparam logic [4:0] OP_SE8_0  = 5'b00100;
  localparam logic [4:0] OP_SE8_1  = 5'b00101;
  localparam logic [4:0] OP_SE8_2  = 5'b01001;
  localparam logic [4:0] OP_SE8_3  = 5'b01010;
  localparam logic [4:0] OP_SE8_4  = 5'b01100;
  localparam logic [4:0] OP_SE8_5  = 5'b10010;
  localparam logic [4:0] OP_SE8_6  = 5'b11010;
  localparam logic [4:0] OP_ZE8_0  = 5'b01101;
  localparam logic [4:0] OP_ZE8_1  = 5'b01011;
  localparam logic [4:0] OP_SE4    = 5'b01000;
  localparam logic [4:0] OP_SE5_0  = 5'b10011;
  localparam logic [4:0] OP_SE5_1  = 5'b11011;
  localparam logic [4:0] OP_SH3    = 5'b00110;

  // A zero shift field encodes a shift of eight.
  localparam logic [DATA_W-1:0] SH3_ZERO_IMM = 16'd8;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] inst;
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] imm;
    fmt_e              fmt;
  } payload_t;

endpackage

// File: rtl/id_imm_stage_imm_gen.sv
// Combinational immediate formatter: classifies the opcode and produces the
// 16-bit extended immediate together with its format code.
module id_imm_stage_imm_gen
  import id_imm_stage_pkg::*;
(
  input  logic [DATA_W-1:0] i_inst,
  output fmt_e              o_fmt,
  output logic [DATA_W-1:0] o_imm
);

  logic [4:0] w_op;
  assign w_op = i_inst[15:11];

  always_comb begin
    o_fmt = FMT_NONE;
    o_imm = '0;
    case (w_op)
      OP_SE11_B: begin
        o_fmt = FMT_SE11;
        o_imm = {{5{i_inst[10]}}, i_inst[10:0]};
      end
      OP_SE8_0, OP_SE8_1, OP_SE8_2, OP_SE8_3, OP_SE8_4, OP_SE8_5, OP_SE8_6: begin
        o_fmt = FMT_SE8;
        o_imm = {{8{i_inst[7]}}, i_inst[7:0]};
      end
      OP_ZE8_0, OP_ZE8_1: begin
        o_fmt = FMT_ZE8;
        o_imm = {8'h00, i_inst[7:0]};
      end
      OP_SE4: begin
        o_fmt = FMT_SE4;
        o_imm = {{12{i_inst[3]}}, i_inst[3:0]};
      end
      OP_SE5_0, OP_SE5_1: begin
        o_fmt = FMT_SE5;
        o_imm = {{11{i_inst[4]}}, i_inst[4:0]};
      end
      OP_SH3: begin
        o_fmt = FMT_SH3;
        o_imm = (i_inst[4:2] == 3'd0) ? SH3_ZERO_IMM : {13'd0, i_inst[4:2]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_imm_stage.sv
// Decode-stage immediate sequencer: formats the immediate on the input side and
// buffers up to two instructions in a main/skid pair toward ID/EX.
//
// state    | meaning
// ST_EMPTY | nothing held, out_valid=0
// ST_ONE   | main register holds the oldest instruction
// ST_TWO   | main and skid both held, intake stalled
module id_imm_stage
  import id_imm_stage_pkg::*;
#(
  parameter int IMM_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IMM_W-1:0] in_inst,
  input  logic [IMM_W-1:0] in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IMM_W-1:0] out_inst,
  output logic [IMM_W-1:0] out_pc,
  output logic [IMM_W-1:0] out_imm,
  output logic [2:0]       out_fmt
);

  buf_state_e        r_state;
  buf_state_e        w_state_nxt;
  payload_t          r_main;
  payload_t          r_skid;
  payload_t          w_new;
  logic              r_in_ready;
  logic              w_accept;
  logic              w_emit;
  logic              w_load_main;
  logic              w_load_skid;
  logic              w_promote;
  fmt_e              w_fmt;
  logic [DATA_W-1:0] w_imm;

  id_imm_stage_imm_gen u_imm_gen (
    .i_inst (in_inst),
    .o_fmt  (w_fmt),
    .o_imm  (w_imm)
  );

  assign w_new = '{inst: in_inst, pc: in_pc, imm: w_imm, fmt: w_fmt};

  assign w_accept = in_valid & r_in_ready;
  assign w_emit   = (r_state != ST_EMPTY) & out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_load_main = 1'b0;
    w_load_skid = 1'b0;
    w_promote   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt = ST_ONE;
          w_load_main = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_accept && w_emit) begin
          w_load_main = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = ST_TWO;
          w_load_skid = 1'b1;
        end else if (w_emit) begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_emit) begin
          w_state_nxt = ST_ONE;
          w_promote   = 1'b1;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush wins over everything, including a same-cycle accept.
    if (flush) begin
      w_state_nxt = ST_EMPTY;
      w_load_main = 1'b0;
      w_load_skid = 1'b0;
      w_promote   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= (w_state_nxt != ST_TWO);
      if (w_load_main) begin
        r_main <= w_new;
      end else if (w_promote) begin
        r_main <= r_skid;
      end
      if (w_load_skid) begin
        r_skid <= w_new;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state != ST_EMPTY);
  assign out_inst  = r_main.inst;
  assign out_pc    = r_main.pc;
  assign out_imm   = r_main.imm;
  assign out_fmt   = r_main.fmt;

endmodule

// File: tb/tb_id_imm_stage.sv
// Bench for id_imm_stage: format vector table, back-pressure/flush/reset
// sequences, and random valid/ready traffic against a queue reference.
module tb_id_imm_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_inst;
  logic [15:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_inst;
  logic [15:0] out_pc;
  logic [15:0] out_imm;
  logic [2:0]  out_fmt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_imm_stage #(.IMM_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_pc    (out_pc),
    .out_imm   (out_imm),
    .out_fmt   (out_fmt)
  );

  typedef struct {
    logic [15:0] inst;
    logic [15:0] imm;
    logic [2:0]  fmt;
  } vec_t;

  vec_t        vecs[13];
  logic [15:0] got[$];
  logic [15:0] q_inst[$];
  logic [15:0] q_pc[$];
  int          acc_cnt;
  int          n_cyc;
  int          n_acc;
  logic        acc;
  logic        stall_prev;
  logic [15:0] p_inst, p_pc, p_imm;
  logic [2:0]  p_fmt;
  logic [15:0] e_imm;
  logic [2:0]  e_fmt;
  logic [15:0] pc_ctr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference formatter: field value as a signed/unsigned integer, truncated to 16 bits.
  function automatic void ref_imm(input logic [15:0] inst, output logic [15:0] imm,
                                  output logic [2:0] fmt);
    int op;
    int v;
    op  = int'(inst[15:11]);
    v   = 0;
    fmt = 3'd0;
    if (op == 2) begin
      fmt = 3'd1; v = int'(inst[10:0]); if (v >= 1024) v -= 2048;
    end else if (op == 4 || op == 5 || op == 9 || op == 10 || op == 12 || op == 18 || op == 26) begin
      fmt = 3'd2; v = int'(inst[7:0]); if (v >= 128) v -= 256;
    end else if (op == 13 || op == 11) begin
      fmt = 3'd3; v = int'(inst[7:0]);
    end else if (op == 8) begin
      fmt = 3'd4; v = int'(inst[3:0]); if (v >= 8) v -= 16;
    end else if (op == 19 || op == 27) begin
      fmt = 3'd5; v = int'(inst[4:0]); if (v >= 16) v -= 32;
    end else if (op == 6) begin
      fmt = 3'd6; v = int'(inst[4:2]); if (v == 0) v = 8;
    end
    imm = 16'(v);
  endfunction

  initial begin
    vecs[0]  = '{16'h17FF, 16'hFFFF, 3'd1};
    vecs[1]  = '{16'h4008, 16'hFFF8, 3'd4};
    vecs[2]  = '{16'h6880, 16'h0080, 3'd3};
    vecs[3]  = '{16'h3000, 16'h0008, 3'd6};
    vecs[4]  = '{16'h1400, 16'hFC00, 3'd1};
    vecs[5]  = '{16'h207F, 16'h007F, 3'd2};
    vecs[6]  = '{16'h301C, 16'h0007, 3'd6};
    vecs[7]  = '{16'h9810, 16'hFFF0, 3'd5};
    vecs[8]  = '{16'hF8FF, 16'h0000, 3'd0};
    vecs[9]  = '{16'h0000, 16'h0000, 3'd0};
    vecs[10] = '{16'hD080, 16'hFF80, 3'd2};
    vecs[11] = '{16'h5F7F, 16'h007F, 3'd3};
    vecs[12] = '{16'h4007, 16'h0007, 3'd4};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_inst = '0; in_pc = '0; out_ready = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_inst", out_inst, 0);
    check("rst_out_pc", out_pc, 0);
    check("rst_out_imm", out_imm, 0);
    check("rst_out_fmt", out_fmt, 0);
    rst = 1'b0;
    tick();
    check("idle_out_valid", out_valid, 0);
    check("idle_in_ready", in_ready, 1);

    // Format table, one instruction per cycle.
    out_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1; in_inst = vecs[i].inst; in_pc = 16'(i);
      tick();
      check("vec_valid", out_valid, 1);
      check("vec_pc", out_pc, 32'(i));
      check("vec_inst", out_inst, vecs[i].inst);
      check("vec_imm", out_imm, vecs[i].imm);
      check("vec_fmt", out_fmt, vecs[i].fmt);
    end
    in_valid = 1'b0;
    tick();
    check("vec_drain_valid", out_valid, 0);

    // Back-pressure with PCs 0..3.
    out_ready = 1'b0; in_valid = 1'b1; acc_cnt = 0;
    for (int c = 0; c < 3; c++) begin
      in_pc = 16'(acc_cnt); in_inst = 16'h2000 | 16'(acc_cnt);
      acc = in_ready;
      tick();
      if (acc) acc_cnt++;
      check("bp_hold_pc", out_pc, 0);
      check("bp_hold_valid", out_valid, 1);
    end
    check("bp_accepts", acc_cnt, 2);
    check("bp_in_ready_low", in_ready, 0);
    out_ready = 1'b1; n_cyc = 0; got.delete();
    while (got.size() < 4 && n_cyc < 20) begin
      in_valid = (acc_cnt < 4);
      in_pc = 16'(acc_cnt); in_inst = 16'h2000 | 16'(acc_cnt);
      if (out_valid) got.push_back(out_pc);
      acc = in_valid && in_ready;
      tick();
      n_cyc++;
      if (acc) acc_cnt++;
    end
    in_valid = 1'b0;
    check("bp_emitted", got.size(), 4);
    check("bp_no_gaps", n_cyc, 4);
    for (int k = 0; k < got.size(); k++) check("bp_order", got[k], 32'(k));
    tick();
    check("bp_empty", out_valid, 0);

    // Flush while TWO with a live input.
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 16'h2011;
    in_pc = 16'h0100; tick();
    in_pc = 16'h0101; tick();
    check("fl_two_in_ready", in_ready, 0);
    flush = 1'b1; in_pc = 16'h0102; tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_two_valid", out_valid, 0);
    check("fl_two_in_ready_back", in_ready, 1);
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("fl_two_stays_empty", out_valid, 0);
    end
    in_valid = 1'b1; in_inst = 16'h3000; in_pc = 16'h0300; tick();
    in_valid = 1'b0;
    check("fl_after_pc", out_pc, 16'h0300);
    check("fl_after_imm", out_imm, 16'h0008);
    tick();

    // Flush in ONE with a same-cycle accept.
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 16'h17FF; in_pc = 16'h0400; tick();
    flush = 1'b1; in_pc = 16'h0401; tick();
    flush = 1'b0; in_valid = 1'b0;
    check("fl_one_valid", out_valid, 0);
    check("fl_one_in_ready", in_ready, 1);
    out_ready = 1'b1; tick();
    check("fl_one_no_ghost", out_valid, 0);

    // Reset together with flush while full.
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 16'h4008;
    in_pc = 16'h0500; tick();
    in_pc = 16'h0501; tick();
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_pc", out_pc, 0);
    check("rst_mid_imm", out_imm, 0);
    check("rst_mid_fmt", out_fmt, 0);

    // Random traffic against a reference queue.
    n_acc = 0; n_cyc = 0; stall_prev = 1'b0; pc_ctr = 16'h1000;
    q_inst.delete(); q_pc.delete();
    out_ready = 1'b0; in_valid = 1'b0; flush = 1'b0;
    while ((n_acc < 1000 || q_inst.size() > 0) && n_cyc < 20000) begin
      check("rnd_in_ready", in_ready, q_inst.size() < 2);
      check("rnd_out_valid", out_valid, q_inst.size() != 0);
      if (stall_prev) begin
        check("rnd_stable_inst", out_inst, p_inst);
        check("rnd_stable_pc", out_pc, p_pc);
        check("rnd_stable_imm", out_imm, p_imm);
        check("rnd_stable_fmt", out_fmt, p_fmt);
      end
      in_valid  = (n_acc < 1000) && ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 199) == 0);
      in_inst   = 16'($urandom);
      in_pc     = pc_ctr;
      stall_prev = out_valid && !out_ready && !flush;
      p_inst = out_inst; p_pc = out_pc; p_imm = out_imm; p_fmt = out_fmt;
      if (flush) begin
        q_inst.delete(); q_pc.delete();
      end else begin
        if (out_valid && out_ready && q_inst.size() > 0) begin
          ref_imm(q_inst[0], e_imm, e_fmt);
          check("rnd_inst", out_inst, q_inst[0]);
          check("rnd_pc", out_pc, q_pc[0]);
          check("rnd_imm", out_imm, e_imm);
          check("rnd_fmt", out_fmt, e_fmt);
          void'(q_inst.pop_front());
          void'(q_pc.pop_front());
        end
        if (in_valid && in_ready) begin
          q_inst.push_back(in_inst);
          q_pc.push_back(in_pc);
          n_acc++;
          pc_ctr++;
        end
      end
      tick();
      n_cyc++;
    end
    flush = 1'b0; in_valid = 1'b0;
    check("rnd_completed", n_cyc < 20000, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
